// File: rtl/pcs_block_lock_mlane.sv
// Multi-lane 64b/66b block-lock engine: independent per-lane lock FSMs plus a registered all-lanes-locked flag.
// Optional SLIP-state timeout is built only when BLOCK_LOCK_SLIP_TIMEOUT_EN is defined.
module pcs_block_lock_mlane #(
    parameter int NUM_LANES = 4,
    parameter int SH_WIN    = 64,
    parameter int INV_LIMIT = 16,
    parameter int SLIP_TO   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 signal_ok,
    input  logic [NUM_LANES-1:0] in_enable,
    input  logic [NUM_LANES-1:0] test_sh,
    input  logic [NUM_LANES-1:0] sh_valid,
    input  logic [NUM_LANES-1:0] slip_done,
    output logic [NUM_LANES-1:0] block_lock,
    output logic [NUM_LANES-1:0] slip,
    output logic [NUM_LANES-1:0] slip_timeout,
    output logic                 all_lock
);
    localparam int SHW = $clog2(SH_WIN + 1);
    localparam int IW  = $clog2(INV_LIMIT + 1);
    localparam logic [SHW-1:0] SH_TOP  = SHW'(SH_WIN);
    localparam logic [IW-1:0]  INV_TOP = IW'(INV_LIMIT);

    if (NUM_LANES < 1 || NUM_LANES > 16 || SH_WIN < 4 || SH_WIN > 1024 ||
        (SH_WIN & (SH_WIN - 1)) != 0 || INV_LIMIT < 1 || INV_LIMIT > SH_WIN ||
        SLIP_TO < 1 || SLIP_TO > 65535) begin : g_bad_param
        $error("pcs_block_lock_mlane: parameter out of range");
    end

    typedef enum logic [1:0] {S_INIT, S_RESET_CNT, S_TEST, S_SLIP} state_e;

    state_e               state_q   [NUM_LANES];
    state_e               state_d   [NUM_LANES];
    logic [SHW-1:0]       sh_cnt_q  [NUM_LANES];
    logic [SHW-1:0]       sh_cnt_d  [NUM_LANES];
    logic [SHW-1:0]       sh_inc    [NUM_LANES];
    logic [IW-1:0]        inv_cnt_q [NUM_LANES];
    logic [IW-1:0]        inv_cnt_d [NUM_LANES];
    logic [IW-1:0]        inv_inc   [NUM_LANES];
    logic [NUM_LANES-1:0] lock_q, lock_d, slip_q, slip_d;
    logic [NUM_LANES-1:0] ev_slip, ev_lock;
    logic                 all_lock_q;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
    logic [15:0]          to_cnt_q  [NUM_LANES];
    logic [15:0]          to_cnt_d  [NUM_LANES];
    logic [NUM_LANES-1:0] tmo_q, tmo_d, ev_tmo;
`endif

    // Saturating increments; a counter at its top value never wraps.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign sh_inc[g]  = (sh_cnt_q[g] == SH_TOP) ? sh_cnt_q[g] : sh_cnt_q[g] + SHW'(1);
        assign inv_inc[g] = (!sh_valid[g] && inv_cnt_q[g] != INV_TOP) ? inv_cnt_q[g] + IW'(1)
                                                                        : inv_cnt_q[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i]   <= S_INIT;
                sh_cnt_q[i]  <= '0;
                inv_cnt_q[i] <= '0;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
                to_cnt_q[i]  <= '0;
`endif
            end
            lock_q     <= '0;
            slip_q     <= '0;
            all_lock_q <= 1'b0;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
            all_lock_q <= &lock_d;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    always_comb begin
        ev_slip = '0;
        ev_lock = '0;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
        ev_tmo  = '0;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i]   = state_q[i];
            sh_cnt_d[i]  = sh_cnt_q[i];
            inv_cnt_d[i] = inv_cnt_q[i];
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
            to_cnt_d[i]  = to_cnt_q[i];
`endif
            if (!signal_ok) begin
                state_d[i]   = S_INIT;
                sh_cnt_d[i]  = '0;
                inv_cnt_d[i] = '0;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
                to_cnt_d[i]  = '0;
`endif
            end else if (in_enable[i]) begin
                unique case (state_q[i])
                    S_INIT:      state_d[i] = S_RESET_CNT;
                    S_RESET_CNT: begin
                        sh_cnt_d[i]  = '0;
                        inv_cnt_d[i] = '0;
                        state_d[i]   = S_TEST;
                    end
                    S_TEST: if (test_sh[i]) begin
                        sh_cnt_d[i]  = sh_inc[i];
                        inv_cnt_d[i] = inv_inc[i];
                        // Slip outranks window completion on the same header.
                        if (!sh_valid[i] && (!lock_q[i] || inv_inc[i] == INV_TOP)) begin
                            state_d[i] = S_SLIP;
                            ev_slip[i] = 1'b1;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
                            to_cnt_d[i] = '0;
`endif
                        end else if (sh_inc[i] == SH_TOP) begin
                            state_d[i] = S_RESET_CNT;
                            ev_lock[i] = (inv_inc[i] == '0);
                        end
                    end
                    S_SLIP: begin
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
                        to_cnt_d[i] = to_cnt_q[i] + 16'd1;
                        if (slip_done[i]) begin
                            state_d[i] = S_RESET_CNT;
                        end else if (to_cnt_d[i] == 16'(SLIP_TO)) begin
                            state_d[i] = S_RESET_CNT;
                            ev_tmo[i]  = 1'b1;
                        end
`else
                        if (slip_done[i]) state_d[i] = S_RESET_CNT;
`endif
                    end
                    default:     state_d[i] = S_INIT;
                endcase
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        slip_d = '0;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
        tmo_d  = ev_tmo;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!signal_ok || ev_slip[i]) lock_d[i] = 1'b0;
            else if (ev_lock[i])          lock_d[i] = 1'b1;
            slip_d[i] = (state_d[i] == S_SLIP);
        end
    end

    assign block_lock = lock_q;
    assign slip       = slip_q;
    assign all_lock   = all_lock_q;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
    assign slip_timeout = tmo_q;
`else
    assign slip_timeout = '0;
`endif

endmodule

// File: tb/tb_pcs_block_lock_mlane.sv
// Self-checking bench for pcs_block_lock_mlane: directed vector table, corner sequences, random run vs. header-level model.
module tb_pcs_block_lock_mlane;
    localparam int NL  = 4;
    localparam int SW  = 64;
    localparam int IL  = 16;
    localparam int STO = 8;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          signal_ok;
    logic [NL-1:0] in_enable, test_sh, sh_valid, slip_done;
    logic [NL-1:0] block_lock, slip, slip_timeout;
    logic          all_lock;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcs_block_lock_mlane #(.NUM_LANES(NL), .SH_WIN(SW), .INV_LIMIT(IL), .SLIP_TO(STO)) dut (
        .clk(clk), .reset_n(reset_n), .signal_ok(signal_ok), .in_enable(in_enable),
        .test_sh(test_sh), .sh_valid(sh_valid), .slip_done(slip_done),
        .block_lock(block_lock), .slip(slip), .slip_timeout(slip_timeout), .all_lock(all_lock)
    );

    // Reference model: per lane, a lock flag, a slip flag, a count of dead
    // (non-counting) enabled cycles still owed, and the window's header tallies.
    logic [NL-1:0] m_lock, m_slip, m_tmo;
    int m_ignore [NL];
    int m_hdrs   [NL];
    int m_bad    [NL];
    int m_tcnt   [NL];

    task automatic model_reset();
        m_lock = '0; m_slip = '0; m_tmo = '0;
        for (int i = 0; i < NL; i++) begin
            m_ignore[i] = 2; m_hdrs[i] = 0; m_bad[i] = 0; m_tcnt[i] = 0;
        end
    endtask

    task automatic model_edge(input logic sok, input logic [NL-1:0] en, tsh, shv, sd);
        for (int i = 0; i < NL; i++) begin
            m_tmo[i] = 1'b0;
            if (!sok) begin
                m_lock[i] = 1'b0; m_slip[i] = 1'b0; m_ignore[i] = 2;
                m_hdrs[i] = 0; m_bad[i] = 0; m_tcnt[i] = 0;
            end else if (en[i]) begin
                if (m_slip[i]) begin
                    m_tcnt[i]++;
                    if (sd[i]) begin
                        m_slip[i] = 1'b0; m_ignore[i] = 1;
                    end else if (TO_EN && m_tcnt[i] == STO) begin
                        m_slip[i] = 1'b0; m_ignore[i] = 1; m_tmo[i] = 1'b1;
                    end
                end else if (m_ignore[i] > 0) begin
                    m_ignore[i]--; m_hdrs[i] = 0; m_bad[i] = 0;
                end else if (tsh[i]) begin
                    m_hdrs[i]++;
                    if (!shv[i]) m_bad[i]++;
                    if (!shv[i] && (!m_lock[i] || m_bad[i] == IL)) begin
                        m_lock[i] = 1'b0; m_slip[i] = 1'b1; m_tcnt[i] = 0;
                    end else if (m_hdrs[i] == SW) begin
                        if (m_bad[i] == 0) m_lock[i] = 1'b1;
                        m_ignore[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic sok, input logic [NL-1:0] en, tsh, shv, sd);
        signal_ok = sok; in_enable = en; test_sh = tsh; sh_valid = shv; slip_done = sd;
        model_edge(sok, en, tsh, shv, sd);
        @(posedge clk);
        #1;
        chk("block_lock", 32'(block_lock), 32'(m_lock));
        chk("slip", 32'(slip), 32'(m_slip));
        chk("slip_timeout", 32'(slip_timeout), 32'(m_tmo));
        chk("all_lock", 32'(all_lock), 32'(&m_lock));
    endtask

    typedef struct {
        int            n;
        logic          sok;
        logic [NL-1:0] en, tsh, shv, sd, e_lock, e_slip;
        logic          e_all;
    } vec_t;

    function automatic vec_t mk(int n, logic sok, logic [3:0] en, tsh, shv, sd, el, es, logic ea);
        vec_t v;
        v.n = n; v.sok = sok; v.en = en; v.tsh = tsh; v.shv = shv; v.sd = sd;
        v.e_lock = el; v.e_slip = es; v.e_all = ea;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        int pulses;
        int vrate;
        logic [NL-1:0] r_en, r_shv, r_sd;

        tbl.push_back(mk( 2, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 0)); // settle to TEST
        tbl.push_back(mk(63, 1, 4'hF, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk( 1, 1, 4'hF, 4'h1, 4'hF, 4'h0, 4'h1, 4'h0, 0)); // 64th header locks lane 0
        tbl.push_back(mk( 1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h1, 4'h0, 0));
        tbl.push_back(mk(64, 1, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 1)); // all lanes lock
        tbl.push_back(mk( 1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk( 1, 0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 0)); // signal loss
        tbl.push_back(mk( 2, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk( 9, 1, 4'hF, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk( 1, 1, 4'hF, 4'h2, 4'hD, 4'h0, 4'h0, 4'h2, 0)); // 10th header bad
        tbl.push_back(mk( 3, 1, 4'hF, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 0)); // headers ignored in SLIP
        tbl.push_back(mk( 1, 1, 4'hF, 4'h0, 4'hF, 4'h2, 4'h0, 4'h0, 0)); // slip_done
        tbl.push_back(mk( 1, 1, 4'hF, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 0)); // RESET_CNT ignores header
        tbl.push_back(mk(63, 1, 4'hF, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk( 1, 1, 4'hF, 4'h2, 4'hF, 4'h0, 4'h2, 4'h0, 0)); // relock lane 1
        tbl.push_back(mk( 1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h2, 4'h0, 0));
        tbl.push_back(mk(64, 1, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk( 1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk(15, 1, 4'hF, 4'h4, 4'hB, 4'h0, 4'hF, 4'h0, 1)); // 15 bad: lock held
        tbl.push_back(mk(49, 1, 4'hF, 4'h4, 4'hF, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk( 1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk(15, 1, 4'hF, 4'h4, 4'hB, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk( 1, 1, 4'hF, 4'h4, 4'hB, 4'h0, 4'hB, 4'h4, 0)); // 16th bad drops lock
        tbl.push_back(mk(10, 1, 4'hB, 4'h8, 4'h7, 4'h0, 4'hB, 4'h4, 0));
        tbl.push_back(mk(20, 1, 4'h3, 4'h8, 4'h7, 4'h0, 4'hB, 4'h4, 0)); // lane 3 frozen
        tbl.push_back(mk( 5, 1, 4'hB, 4'h8, 4'h7, 4'h0, 4'hB, 4'h4, 0));
        tbl.push_back(mk( 1, 1, 4'hB, 4'h8, 4'h7, 4'h0, 4'h3, 4'hC, 0)); // 16th counted bad
        tbl.push_back(mk( 1, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 0)); // signal loss while frozen

        reset_n = 1'b0; signal_ok = 1'b0;
        in_enable = '0; test_sh = '0; sh_valid = '0; slip_done = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_block_lock", 32'(block_lock), 32'h0);
        chk("rst_slip", 32'(slip), 32'h0);
        chk("rst_slip_timeout", 32'(slip_timeout), 32'h0);
        chk("rst_all_lock", 32'(all_lock), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            for (int c = 0; c < tbl[k].n; c++)
                step(tbl[k].sok, tbl[k].en, tbl[k].tsh, tbl[k].shv, tbl[k].sd);
            chk($sformatf("vec%0d_lock", k), 32'(block_lock), 32'(tbl[k].e_lock));
            chk($sformatf("vec%0d_slip", k), 32'(slip), 32'(tbl[k].e_slip));
            chk($sformatf("vec%0d_all", k), 32'(all_lock), 32'(tbl[k].e_all));
        end

        // Asynchronous reset in the middle of SLIP.
        step(1, 4'hF, 4'h0, 4'hF, 4'h0);
        step(1, 4'hF, 4'h0, 4'hF, 4'h0);
        step(1, 4'hF, 4'h1, 4'hE, 4'h0);
        chk("pre_arst_slip", 32'(slip), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_slip", 32'(slip), 32'h0);
        chk("arst_lock", 32'(block_lock), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        step(1, 4'hF, 4'h0, 4'hF, 4'h0);
        step(1, 4'hF, 4'h0, 4'hF, 4'h0);
        step(1, 4'hF, 4'h1, 4'hE, 4'h0);
        chk("enter_slip", 32'(slip[0]), 32'h1);
        pulses = 0;
`ifdef BLOCK_LOCK_SLIP_TIMEOUT_EN
        for (int c = 0; c < 7; c++) begin
            step(1, 4'hF, 4'h0, 4'hF, 4'h0);
            pulses += int'(slip_timeout[0]);
        end
        chk("to_early_slip", 32'(slip[0]), 32'h1);
        step(1, 4'hF, 4'h0, 4'hF, 4'h0);
        pulses += int'(slip_timeout[0]);
        chk("to_pulse", 32'(slip_timeout[0]), 32'h1);
        chk("to_slip_low", 32'(slip[0]), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step(1, 4'hF, 4'h0, 4'hF, 4'h0);
            pulses += int'(slip_timeout[0]);
        end
        chk("to_pulse_count", 32'(pulses), 32'd1);
        step(1, 4'hF, 4'h1, 4'hE, 4'h0);
        for (int c = 0; c < 7; c++) step(1, 4'hF, 4'h0, 4'hF, 4'h0);
        step(1, 4'hF, 4'h0, 4'hF, 4'h1);
        chk("sd_wins_tmo", 32'(slip_timeout[0]), 32'h0);
        chk("sd_wins_slip", 32'(slip[0]), 32'h0);
        step(1, 4'hF, 4'h0, 4'hF, 4'h0);
        chk("sd_wins_tmo_after", 32'(slip_timeout[0]), 32'h0);
`else
        for (int c = 0; c < 1000; c++) begin
            step(1, 4'hF, 4'h0, 4'hF, 4'h0);
            pulses += int'(slip_timeout[0]) + int'(!slip[0]);
        end
        chk("no_to_slip_held", 32'(slip[0]), 32'h1);
        chk("no_to_events", 32'(pulses), 32'd0);
`endif

        // Random run against the model; header error rate varies by segment.
        vrate = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) vrate = int'($urandom_range(0, 3));
            for (int i = 0; i < NL; i++) begin
                r_en[i] = ($urandom_range(0, 7) != 0);
                r_sd[i] = ($urandom_range(0, 11) == 0);
                case (vrate)
                    0:       r_shv[i] = 1'b1;
                    1:       r_shv[i] = ($urandom_range(0, 127) != 0);
                    2:       r_shv[i] = ($urandom_range(0, 39) != 0);
                    default: r_shv[i] = ($urandom_range(0, 2) != 0);
                endcase
            end
            step(($urandom_range(0, 299) != 0), r_en, NL'($urandom), r_shv, r_sd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pcs_block_lock_mlane.md
# pcs_block_lock_mlane

Multi-lane, parametrised block-lock engine for the 25G/10G PCS receive path. It sits between the per-lane sync-header extractors and the gearbox slip logic. Each lane runs an independent 64b/66b lock state machine, with window length and invalid-header limit set by parameters. The block adds an aggregate all-lanes-locked indication and an optional slip-acknowledge timeout.

## Interface
Parameters:
- NUM_LANES, 4, number of independent lanes (1..16)
- SH_WIN, 64, sync headers per test window (power of two, 4..1024)
- INV_LIMIT, 16, invalid headers in one window that drop lock while locked (1..SH_WIN)
- SLIP_TO, 255, SLIP-state timeout in cycles (used only with the macro, 1..65535)

Ports:
- clk  in  1  block clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- signal_ok  in  1  PMA signal detect; 0 forces every lane to INIT
- in_enable  in  NUM_LANES  per-lane clock enable; 0 freezes that lane
- test_sh  in  NUM_LANES  per-lane pulse: a new sync header is present this cycle
- sh_valid  in  NUM_LANES  per-lane header valid (01/10); sampled only with test_sh
- slip_done  in  NUM_LANES  per-lane pulse from the gearbox: slip completed
- block_lock  out  NUM_LANES  per-lane lock status
- slip  out  NUM_LANES  per-lane slip request, level
- slip_timeout  out  NUM_LANES  per-lane one-cycle pulse on SLIP timeout
- all_lock  out  1  AND of all block_lock bits

## Operation
- Per-lane states: INIT, RESET_CNT, TEST, SLIP. Counters: sh_cnt (width clog2(SH_WIN+1)) and inv_cnt (width clog2(INV_LIMIT+1)), both unsigned. An increment at the top value never wraps.
- Priority: reset_n=0, then signal_ok=0, then in_enable[i]=0 (hold state), then the FSM.
- signal_ok=0: state INIT, block_lock=0, slip=0, counters cleared, timeout counter cleared.
- INIT -> RESET_CNT after one enabled cycle.
- RESET_CNT: clears sh_cnt and inv_cnt, then goes to TEST on the next enabled cycle.
- TEST, on an enabled cycle with test_sh=1:
  - sh_cnt+1. If sh_valid=0, inv_cnt+1.
  - Unlocked and sh_valid=0: go to SLIP. block_lock stays 0.
  - Locked and inv_cnt+1 reaches INV_LIMIT: block_lock=0, go to SLIP.
  - sh_cnt+1 reaches SH_WIN with no slip taken: if the window had no invalid headers, block_lock=1. Go to RESET_CNT.
  - The slip condition takes priority over window completion when both occur on the same header.
  - In TEST, cycles with test_sh=0 hold all counters.
- SLIP: slip=1. slip_done=1 goes to RESET_CNT with slip=0. slip_done outside SLIP is ignored. test_sh is ignored in SLIP and RESET_CNT.
- all_lock is registered and equals the AND of the next-state block_lock vector.

## Timing
- Reset values: block_lock=0, slip=0, slip_timeout=0, all_lock=0. All lanes in INIT with counters 0.
- All outputs are registered.
- block_lock and all_lock change on the clock edge that samples the deciding header (one-cycle latency from that test_sh).
- slip rises on the edge that samples the deciding header. It falls on the edge that samples slip_done=1.
- Minimum re-lock time from slip_done: 2 cycles (RESET_CNT, then TEST), plus SH_WIN headers.
- signal_ok deassertion takes effect on the next edge regardless of in_enable. Asynchronous reset takes effect immediately.
- Lanes never interact except through all_lock.

## Configuration
- BLOCK_LOCK_SLIP_TIMEOUT_EN defined:
  - Each lane has a 16-bit counter. It clears on SLIP entry and increments each enabled cycle in SLIP.
  - When the counter reaches SLIP_TO with no slip_done, the lane goes to RESET_CNT, slip=0, and slip_timeout pulses 1 cycle.
  - slip_done on the same cycle wins; no pulse is generated.
- Macro undefined: the lane waits in SLIP indefinitely, slip_timeout is tied 0, and no timeout counter is built.

## Test plan
- Lock: NUM_LANES=4, SH_WIN=64. Apply 64 valid headers on lane 0 (signal_ok=1, lane 0 enabled). Required: block_lock=4'b0001 the cycle after the 64th header, all_lock=0. Repeat on all lanes: all_lock=1.
- Unlocked slip: send an invalid header on the 10th test_sh of lane 1. Required: slip[1]=1 next cycle; it falls the edge after a slip_done pulse; relock after 64 more valid headers.
- Locked tolerance: lane 2 locked, INV_LIMIT=16. Send 15 invalid headers in one window: lock held and the window restarts. A 16th invalid in the same window drops block_lock[2]=0 and raises slip[2]=1. all_lock falls on the same edge.
- Freeze and reset: hold in_enable[3]=0 mid-window while pulsing test_sh: counters and state unchanged. Drop signal_ok for 1 cycle: all lanes clear to INIT, outputs 0. Assert reset_n=0 asynchronously mid-SLIP: slip=0 immediately.
- Timeout (macro defined, SLIP_TO=8): lane in SLIP with no slip_done. Required: slip_timeout pulses exactly once after 8 enabled cycles, slip=0, and the lane restarts. Pulsing slip_done on cycle 8 instead gives no timeout pulse. With the macro undefined, slip stays high for 1000 cycles.
